// File: rtl/reseed_lfsr_prng.sv
// 64-bit Galois LFSR clearing-data generator with an entropy-packing reseed path.
// Define PRNG_NONLINEAR_OUT_EN to pass data0_o through a PRINCE S-box layer.
module reseed_lfsr_prng #(
  parameter int unsigned      Width        = 64,
  parameter int unsigned      EntropyWidth = 32,
  parameter logic [Width-1:0] DefaultSeed  = 64'h1,
  parameter logic [Width-1:0] Coeffs       = 64'hD800_0000_0000_0000
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    data_req_i,
  output logic                    data_ack_o,
  output logic [Width-1:0]        data0_o,
  output logic [Width-1:0]        data1_o,
  input  logic                    reseed_req_i,
  output logic                    reseed_ack_o,
  output logic                    entropy_req_o,
  input  logic                    entropy_ack_i,
  input  logic [EntropyWidth-1:0] entropy_i
);

  localparam int unsigned NumWords = Width / EntropyWidth;
  localparam int unsigned CntW     = $clog2(NumWords + 1);

  if (Width != 64) begin : g_width_check
    $error("reseed_lfsr_prng: only Width = 64 is supported");
  end
  if ((Width % EntropyWidth) != 0) begin : g_entropy_check
    $error("reseed_lfsr_prng: Width must be a multiple of EntropyWidth");
  end
  if (DefaultSeed == '0) begin : g_seed_check
    $error("reseed_lfsr_prng: DefaultSeed must be nonzero");
  end

  logic [Width-1:0]                       state_q;
  logic [Width-1:0]                       state_next;
  logic [NumWords-1:0][EntropyWidth-1:0]  words_q;
  logic [CntW-1:0]                        count_q;
  logic                                   seed_valid_q;
  logic                                   step_en;
  logic                                   entropy_accept;

  assign data_ack_o     = data_req_i & ~reseed_req_i;
  assign step_en        = data_req_i & data_ack_o;
  assign entropy_req_o  = reseed_req_i & ~seed_valid_q;
  assign entropy_accept = entropy_req_o & entropy_ack_i;
  assign reseed_ack_o   = seed_valid_q;

  assign state_next = (state_q >> 1) ^ (state_q[0] ? Coeffs : '0);

  // Seed load wins over lockup recovery, which wins over a data step.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= DefaultSeed;
    end else if (seed_valid_q) begin
      state_q <= words_q;
    end else if (state_q == '0) begin
      state_q <= DefaultSeed;
    end else if (step_en) begin
      state_q <= state_next;
    end
  end

  // Partial words survive a dropped reseed request; only a load or reset empties the packer.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      words_q      <= '0;
      count_q      <= '0;
      seed_valid_q <= 1'b0;
    end else if (seed_valid_q) begin
      words_q      <= '0;
      count_q      <= '0;
      seed_valid_q <= 1'b0;
    end else if (entropy_accept) begin
      for (int unsigned i = 0; i < NumWords; i++) begin
        if (count_q == CntW'(i)) begin
          words_q[i] <= entropy_i;
        end
      end
      count_q      <= count_q + CntW'(1);
      seed_valid_q <= (count_q == CntW'(NumWords - 1));
    end
  end

`ifdef PRNG_NONLINEAR_OUT_EN
  function automatic logic [3:0] prince_sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0:    y = 4'hB;
      4'h1:    y = 4'hF;
      4'h2:    y = 4'h3;
      4'h3:    y = 4'h2;
      4'h4:    y = 4'hA;
      4'h5:    y = 4'hC;
      4'h6:    y = 4'h9;
      4'h7:    y = 4'h1;
      4'h8:    y = 4'h6;
      4'h9:    y = 4'h7;
      4'hA:    y = 4'h8;
      4'hB:    y = 4'h0;
      4'hC:    y = 4'hE;
      4'hD:    y = 4'h5;
      4'hE:    y = 4'hD;
      default: y = 4'h4;
    endcase
    return y;
  endfunction

  always_comb begin
    data0_o = '0;
    for (int unsigned n = 0; n < Width / 4; n++) begin
      data0_o[4*n +: 4] = prince_sbox(state_q[4*n +: 4]);
    end
  end
`else
  assign data0_o = state_q;
`endif

  // Share 1 is share 0 bit-reversed.
  for (genvar i = 0; i < Width; i++) begin : g_reverse
    assign data1_o[i] = data0_o[Width-1-i];
  end

endmodule

// File: tb/tb_reseed_lfsr_prng.sv
// Self-checking bench for reseed_lfsr_prng against a queue-based reference model.
// Honours PRNG_NONLINEAR_OUT_EN when predicting the output shares.
module tb_reseed_lfsr_prng;

  localparam logic [63:0] DefaultSeed = 64'h1;
  localparam logic [63:0] Coeffs      = 64'hD800_0000_0000_0000;
  localparam logic [3:0]  Sbox [16]   = '{4'hB, 4'hF, 4'h3, 4'h2, 4'hA, 4'hC, 4'h9, 4'h1,
                                          4'h6, 4'h7, 4'h8, 4'h0, 4'hE, 4'h5, 4'hD, 4'h4};

  logic        clk = 1'b0;
  logic        rst;
  logic        data_req;
  logic        data_ack;
  logic [63:0] data0;
  logic [63:0] data1;
  logic        reseed_req;
  logic        reseed_ack;
  logic        entropy_req;
  logic        entropy_ack;
  logic [31:0] entropy;

  int checks = 0;
  int errors = 0;

  logic [63:0] m_state;
  logic [31:0] m_words[$];
  bit          m_seed_valid;

  always #5 clk = ~clk;

  reseed_lfsr_prng dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .data_req_i    (data_req),
    .data_ack_o    (data_ack),
    .data0_o       (data0),
    .data1_o       (data1),
    .reseed_req_i  (reseed_req),
    .reseed_ack_o  (reseed_ack),
    .entropy_req_o (entropy_req),
    .entropy_ack_i (entropy_ack),
    .entropy_i     (entropy)
  );

  // Galois step viewed as division by x modulo the feedback polynomial.
  function automatic logic [63:0] model_next(input logic [63:0] s);
    if (s % 2 == 1) return (s / 2) ^ Coeffs;
    return s / 2;
  endfunction

  function automatic logic [63:0] exp_data0();
`ifdef PRNG_NONLINEAR_OUT_EN
    logic [63:0] r = '0;
    for (int n = 0; n < 16; n++) begin
      logic [63:0] nib;
      nib = (m_state >> (4 * n)) & 64'hF;
      r = r | (64'(Sbox[nib[3:0]]) << (4 * n));
    end
    return r;
`else
    return m_state;
`endif
  endfunction

  function automatic logic [63:0] exp_data1();
    logic [63:0] d = exp_data0();
    logic [63:0] r = '0;
    for (int i = 0; i < 64; i++) r[63-i] = d[i];
    return r;
  endfunction

  task automatic model_reset();
    m_state = DefaultSeed;
    m_words.delete();
    m_seed_valid = 1'b0;
  endtask

  task automatic model_edge();
    if (rst) begin
      model_reset();
    end else if (m_seed_valid) begin
      m_state = {m_words[1], m_words[0]};
      m_words.delete();
      m_seed_valid = 1'b0;
    end else begin
      if (m_state == 0) m_state = DefaultSeed;
      else if (data_req && !reseed_req) m_state = model_next(m_state);
      if (entropy_ack && reseed_req) begin
        m_words.push_back(entropy);
        if (m_words.size() == 2) m_seed_valid = 1'b1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; data_req = 1'b0; reseed_req = 1'b0; entropy_ack = 1'b0; entropy = '0;
    model_reset();
    tick();
    tick();
    checks++;
    if (data0 !== exp_data0()) begin
      errors++; $display("[TB] FAIL reset_data0: got %h expected %h", data0, exp_data0());
    end
`ifdef PRNG_NONLINEAR_OUT_EN
    checks++;
    if (data0 !== 64'hBBBB_BBBB_BBBB_BBBF) begin
      errors++; $display("[TB] FAIL reset_data0_sbox: got %h expected %h", data0, 64'hBBBB_BBBB_BBBB_BBBF);
    end
`else
    checks++;
    if (data0 !== 64'h1) begin
      errors++; $display("[TB] FAIL reset_data0_const: got %h expected %h", data0, 64'h1);
    end
    checks++;
    if (data1 !== 64'h8000_0000_0000_0000) begin
      errors++; $display("[TB] FAIL reset_data1_const: got %h expected %h", data1, 64'h8000_0000_0000_0000);
    end
`endif
    checks++;
    if (data1 !== exp_data1()) begin
      errors++; $display("[TB] FAIL reset_data1: got %h expected %h", data1, exp_data1());
    end
    checks++;
    if ({data_ack, entropy_req, reseed_ack} !== 3'b000) begin
      errors++; $display("[TB] FAIL reset_handshakes: got %b expected 000", {data_ack, entropy_req, reseed_ack});
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_step();
    data_req = 1'b1;
    #1;
    checks++;
    if (data_ack !== 1'b1) begin
      errors++; $display("[TB] FAIL step_ack: got %b expected 1", data_ack);
    end
    tick();
    checks++;
    if (data0 !== exp_data0()) begin
      errors++; $display("[TB] FAIL step1_data0: got %h expected %h", data0, exp_data0());
    end
`ifndef PRNG_NONLINEAR_OUT_EN
    checks++;
    if (data0 !== 64'hD800_0000_0000_0000) begin
      errors++; $display("[TB] FAIL step1_const: got %h expected %h", data0, 64'hD800_0000_0000_0000);
    end
`endif
    tick();
    data_req = 1'b0;
    #1;
    checks++;
    if (data0 !== exp_data0()) begin
      errors++; $display("[TB] FAIL step2_data0: got %h expected %h", data0, exp_data0());
    end
`ifndef PRNG_NONLINEAR_OUT_EN
    checks++;
    if (data0 !== 64'h6C00_0000_0000_0000) begin
      errors++; $display("[TB] FAIL step2_const: got %h expected %h", data0, 64'h6C00_0000_0000_0000);
    end
`endif
  endtask

  task automatic test_reseed();
    logic [63:0] held;
    data_req = 1'b1; reseed_req = 1'b1;
    #1;
    held = exp_data0();
    checks++;
    if ({data_ack, entropy_req} !== 2'b01) begin
      errors++; $display("[TB] FAIL reseed_block: got ack,ereq=%b expected 01", {data_ack, entropy_req});
    end
    entropy_ack = 1'b1; entropy = 32'hDEADBEEF;
    tick();
    checks++;
    if (data0 !== held) begin
      errors++; $display("[TB] FAIL reseed_hold: got %h expected %h", data0, held);
    end
    entropy = 32'h01234567;
    tick();
    entropy_ack = 1'b0;
    #1;
    checks++;
    if ({reseed_ack, entropy_req} !== 2'b10) begin
      errors++; $display("[TB] FAIL reseed_ack: got ack,ereq=%b expected 10", {reseed_ack, entropy_req});
    end
    tick();
    reseed_req = 1'b0; data_req = 1'b0;
    #1;
    checks++;
    if (data0 !== exp_data0() || reseed_ack !== 1'b0) begin
      errors++; $display("[TB] FAIL reseed_load: got %h/%b expected %h/0", data0, reseed_ack, exp_data0());
    end
`ifndef PRNG_NONLINEAR_OUT_EN
    checks++;
    if (data0 !== 64'h01234567_DEADBEEF) begin
      errors++; $display("[TB] FAIL reseed_const: got %h expected %h", data0, 64'h01234567_DEADBEEF);
    end
`endif
  endtask

  task automatic test_zero_seed();
    reseed_req = 1'b1; entropy_ack = 1'b1; entropy = '0;
    tick();
    tick();
    entropy_ack = 1'b0;
    tick();
    reseed_req = 1'b0;
    #1;
    checks++;
    if (data0 !== exp_data0()) begin
      errors++; $display("[TB] FAIL zero_load: got %h expected %h", data0, exp_data0());
    end
`ifndef PRNG_NONLINEAR_OUT_EN
    checks++;
    if (data0 !== 64'h0) begin
      errors++; $display("[TB] FAIL zero_const: got %h expected 0", data0);
    end
`endif
    tick();
    checks++;
    if (data0 !== exp_data0()) begin
      errors++; $display("[TB] FAIL zero_recover: got %h expected %h", data0, exp_data0());
    end
`ifndef PRNG_NONLINEAR_OUT_EN
    checks++;
    if (data0 !== 64'h1) begin
      errors++; $display("[TB] FAIL zero_recover_const: got %h expected 1", data0);
    end
`endif
  endtask

  task automatic test_reset_mid_pack();
    logic [31:0] w1;
    logic [31:0] w2;
    w1 = $urandom; w2 = $urandom;
    reseed_req = 1'b1; entropy_ack = 1'b1; entropy = $urandom;
    tick();
    entropy_ack = 1'b0;
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if (data0 !== exp_data0() || entropy_req !== 1'b1) begin
      errors++; $display("[TB] FAIL midreset_state: got %h/%b expected %h/1", data0, entropy_req, exp_data0());
    end
    tick();
    rst = 1'b0;
    entropy_ack = 1'b1; entropy = w1;
    tick();
    entropy_ack = 1'b0;
    #1;
    checks++;
    if (reseed_ack !== 1'b0) begin
      errors++; $display("[TB] FAIL midreset_one_word: got reseed_ack %b expected 0", reseed_ack);
    end
    entropy_ack = 1'b1; entropy = w2;
    tick();
    entropy_ack = 1'b0;
    #1;
    checks++;
    if (reseed_ack !== 1'b1) begin
      errors++; $display("[TB] FAIL midreset_two_words: got reseed_ack %b expected 1", reseed_ack);
    end
    tick();
    reseed_req = 1'b0;
    #1;
    checks++;
    if (data0 !== exp_data0()) begin
      errors++; $display("[TB] FAIL midreset_load: got %h expected %h", data0, exp_data0());
    end
  endtask

  task automatic test_drop_mid_pack();
    logic [31:0] wa;
    logic [31:0] wb;
    wa = $urandom; wb = $urandom;
    reseed_req = 1'b1; entropy_ack = 1'b1; entropy = wa;
    tick();
    reseed_req = 1'b0; data_req = 1'b1; entropy = $urandom;
    #1;
    checks++;
    if (entropy_req !== 1'b0) begin
      errors++; $display("[TB] FAIL drop_ereq: got %b expected 0", entropy_req);
    end
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (data0 !== exp_data0() || reseed_ack !== 1'b0) begin
      errors++; $display("[TB] FAIL drop_steps: got %h/%b expected %h/0", data0, reseed_ack, exp_data0());
    end
    data_req = 1'b0; reseed_req = 1'b1; entropy = wb;
    tick();
    entropy_ack = 1'b0;
    #1;
    checks++;
    if (reseed_ack !== 1'b1) begin
      errors++; $display("[TB] FAIL drop_resume_ack: got %b expected 1", reseed_ack);
    end
    tick();
    reseed_req = 1'b0;
    #1;
    checks++;
    if (data0 !== exp_data0()) begin
      errors++; $display("[TB] FAIL drop_load: got %h expected %h", data0, exp_data0());
    end
`ifndef PRNG_NONLINEAR_OUT_EN
    checks++;
    if (data0 !== {wb, wa}) begin
      errors++; $display("[TB] FAIL drop_load_words: got %h expected %h", data0, {wb, wa});
    end
`endif
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      data_req = 1'($urandom % 2);
      if (reseed_req) reseed_req = ($urandom % 8) != 0;
      else            reseed_req = ($urandom % 4) == 0;
      entropy_ack = 1'($urandom % 2);
      entropy = ($urandom % 4 == 0) ? 32'h0 : 32'($urandom);
      #1;
      checks++;
      if (data_ack !== (data_req & ~reseed_req)) begin
        errors++; $display("[TB] FAIL rand_data_ack@%0d: got %b expected %b", c, data_ack, data_req & ~reseed_req);
      end
      checks++;
      if (entropy_req !== (reseed_req & ~m_seed_valid) || reseed_ack !== m_seed_valid) begin
        errors++; $display("[TB] FAIL rand_reseed_hs@%0d: got ereq,ack=%b%b expected %b%b",
                           c, entropy_req, reseed_ack, reseed_req & ~m_seed_valid, m_seed_valid);
      end
      checks++;
      if (data0 !== exp_data0() || data1 !== exp_data1()) begin
        errors++; $display("[TB] FAIL rand_data@%0d: got %h/%h expected %h/%h", c, data0, data1, exp_data0(), exp_data1());
      end
      tick();
    end
    data_req = 1'b0; reseed_req = 1'b0; entropy_ack = 1'b0;
  endtask

  initial begin
    test_reset();
    test_step();
    test_reseed();
    test_zero_seed();
    test_reset_mid_pack();
    test_drop_mid_pack();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
